pipe_execute: RTL and testbench

Parametrised execute stage for the pipelined Y86 core, the successor to the single-cycle execute unit. Computes ALU result, condition-code update and branch/cmov condition for the instruction in E, and holds the E→M pipeline register with stall/bubble control from the hazard unit. Width-generic, so 32- and 64-bit cores share one stage; also emits combinational forwarding values for decode.

---
 rtl/y86_pkg.sv | 46 ++++
 rtl/y86_alu.sv | 51 +++++
 rtl/pipe_execute.sv | 170 +++++++++++++++++
 tb/tb_pipe_execute.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 encodings for the pipelined core: instruction codes, ALU
// function codes, branch/cmov condition codes, stage status codes.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  typedef enum logic [2:0] {
    STAT_BUB = 3'd0,
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  localparam logic [3:0] RNONE = 4'hF;

  // Only ADD/SUB/AND/XOR exist; any other OPq function is an illegal instruction.
  function automatic logic aluFunValid(input logic [3:0] fun);
    return fun <= ALU_XOR;
  endfunction

endpackage

// File: rtl/y86_alu.sv
// Width-generic combinational Y86 ALU producing the result and the three
// condition flags for that result. Undefined function codes yield zero.
module y86_alu #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_fun,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zf,
  output logic             o_sf,
  output logic             o_of
);
  import y86_pkg::*;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_addOf;
  logic             w_subOf;

  assign w_sum  = i_b + i_a;
  assign w_diff = i_b - i_a;

  // Signed overflow: add overflows when like-signed operands give an unlike-signed
  // sum; subtract overflows when unlike-signed operands flip the sign of B.
  assign w_addOf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1]  != i_a[WIDTH-1]);
  assign w_subOf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_b[WIDTH-1]);

  // Select the operation result and its overflow flag.
  always_comb begin
    o_result = '0;
    o_of     = 1'b0;
    case (i_fun)
      ALU_ADD: begin
        o_result = w_sum;
        o_of     = w_addOf;
      end
      ALU_SUB: begin
        o_result = w_diff;
        o_of     = w_subOf;
      end
      ALU_AND: o_result = i_b & i_a;
      ALU_XOR: o_result = i_b ^ i_a;
      default: o_result = '0;
    endcase
  end

  assign o_zf = (o_result == '0);
  assign o_sf = o_result[WIDTH-1];

endmodule

// File: rtl/pipe_execute.sv
// Execute stage of the pipelined Y86 core: operand selection, ALU, condition
// codes, branch/cmov condition, forwarding outputs and the E->M register.
module pipe_execute #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [WIDTH-1:0] E_valB,
  input  logic [WIDTH-1:0] E_valC,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic             cc_inhibit,
  input  logic             m_stall,
  input  logic             m_bubble,
  output logic [WIDTH-1:0] e_valE,
  output logic [3:0]       e_dstE,
  output logic             ZF,
  output logic             SF,
  output logic             OF,
  output logic [2:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM
);
  import y86_pkg::*;

  // Stack pointer adjustment per push/pop/call/ret, in bytes.
  localparam logic [WIDTH-1:0] STEP = WIDTH'(WIDTH / 8);

  logic [WIDTH-1:0] w_aluA;
  logic [WIDTH-1:0] w_aluB;
  logic [3:0]       w_aluFun;
  logic             w_isOpq;
  logic             w_funValid;
  logic [WIDTH-1:0] w_aluResult;
  logic             w_aluZf;
  logic             w_aluSf;
  logic             w_aluOf;
  logic             w_setCc;
  logic             w_cond;
  logic [2:0]       w_stat;

  logic             r_zf;
  logic             r_sf;
  logic             r_of;
  logic [2:0]       r_mStat;
  logic [3:0]       r_mIcode;
  logic             r_mCnd;
  logic [WIDTH-1:0] r_mValE;
  logic [WIDTH-1:0] r_mValA;
  logic [3:0]       r_mDstE;
  logic [3:0]       r_mDstM;

  assign w_isOpq    = (E_icode == I_OPQ);
  assign w_aluFun   = w_isOpq ? E_ifun : ALU_ADD;
  assign w_funValid = aluFunValid(w_aluFun);

  // Pick ALU operands by instruction class; stack ops add +/- one word.
  always_comb begin
    w_aluA = '0;
    w_aluB = '0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:            w_aluA = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: w_aluA = E_valC;
      I_CALL, I_PUSHQ:            w_aluA = -STEP;
      I_RET, I_POPQ:              w_aluA = STEP;
      default:                    w_aluA = '0;
    endcase
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: w_aluB = E_valB;
      default:                                                   w_aluB = '0;
    endcase
  end

  y86_alu #(.WIDTH(WIDTH)) u_alu (
    .i_a      (w_aluA),
    .i_b      (w_aluB),
    .i_fun    (w_aluFun),
    .o_result (w_aluResult),
    .o_zf     (w_aluZf),
    .o_sf     (w_aluSf),
    .o_of     (w_aluOf)
  );

  // Evaluate the jump/cmov condition against the CC values before this instruction's update.
  always_comb begin
    w_cond = 1'b0;
    case (E_ifun)
      C_YES:   w_cond = 1'b1;
      C_LE:    w_cond = (r_sf ^ r_of) | r_zf;
      C_L:     w_cond = r_sf ^ r_of;
      C_E:     w_cond = r_zf;
      C_NE:    w_cond = ~r_zf;
      C_GE:    w_cond = ~(r_sf ^ r_of);
      C_G:     w_cond = ~(r_sf ^ r_of) & ~r_zf;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_setCc = w_isOpq && w_funValid && (E_stat == STAT_AOK) && !cc_inhibit && !m_stall;

  // An undefined OPq function on an otherwise healthy instruction becomes an INS fault.
  assign w_stat = (w_isOpq && !w_funValid && E_stat == STAT_AOK) ? STAT_INS : E_stat;

  assign e_valE = w_aluResult;
  assign e_dstE = (E_icode == I_RRMOVQ && !w_cond) ? RNONE : E_dstE;

  // Condition-code register; held during an M stall so a stalled OPq updates it only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (w_setCc) begin
      r_zf <= w_aluZf;
      r_sf <= w_aluSf;
      r_of <= w_aluOf;
    end
  end

  // E->M pipeline register: stall holds, bubble inserts a NOP, otherwise load E.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mStat  <= STAT_BUB;
      r_mIcode <= I_NOP;
      r_mCnd   <= 1'b0;
      r_mValE  <= '0;
      r_mValA  <= '0;
      r_mDstE  <= RNONE;
      r_mDstM  <= RNONE;
    end else if (!m_stall) begin
      if (m_bubble) begin
        r_mStat  <= STAT_BUB;
        r_mIcode <= I_NOP;
        r_mCnd   <= 1'b0;
        r_mValE  <= '0;
        r_mValA  <= '0;
        r_mDstE  <= RNONE;
        r_mDstM  <= RNONE;
      end else begin
        r_mStat  <= w_stat;
        r_mIcode <= E_icode;
        r_mCnd   <= (E_icode == I_RRMOVQ || E_icode == I_JXX) ? w_cond : 1'b0;
        r_mValE  <= e_valE;
        r_mValA  <= E_valA;
        r_mDstE  <= e_dstE;
        r_mDstM  <= E_dstM;
      end
    end
  end

  assign ZF      = r_zf;
  assign SF      = r_sf;
  assign OF      = r_of;
  assign M_stat  = r_mStat;
  assign M_icode = r_mIcode;
  assign M_cnd   = r_mCnd;
  assign M_valE  = r_mValE;
  assign M_valA  = r_mValA;
  assign M_dstE  = r_mDstE;
  assign M_dstM  = r_mDstM;

endmodule

// File: tb/tb_pipe_execute.sv
// Testbench for pipe_execute: directed scenarios plus randomized instructions
// compared against an arithmetic reference model of the execute stage.
module tb_pipe_execute;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   E_stat;
  logic [3:0]   E_icode, E_ifun;
  logic [W-1:0] E_valA, E_valB, E_valC;
  logic [3:0]   E_dstE, E_dstM;
  logic         cc_inhibit, m_stall, m_bubble;

  logic [W-1:0] e_valE;
  logic [3:0]   e_dstE;
  logic         ZF, SF, OF;
  logic [2:0]   M_stat;
  logic [3:0]   M_icode;
  logic         M_cnd;
  logic [W-1:0] M_valE, M_valA;
  logic [3:0]   M_dstE, M_dstM;

  logic [31:0]  e_valE32;
  logic [3:0]   e_dstE32;
  logic         ZF32, SF32, OF32;
  logic [2:0]   M_stat32;
  logic [3:0]   M_icode32;
  logic         M_cnd32;
  logic [31:0]  M_valE32, M_valA32;
  logic [3:0]   M_dstE32, M_dstM32;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state: condition codes and the expected M register.
  logic         mZF, mSF, mOF;
  logic [2:0]   xStat;
  logic [3:0]   xIcode;
  logic         xCnd;
  logic [W-1:0] xValE, xValA;
  logic [3:0]   xDstE, xDstM;

  always #5 clk = ~clk;

  pipe_execute #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .cc_inhibit(cc_inhibit), .m_stall(m_stall), .m_bubble(m_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .ZF(ZF), .SF(SF), .OF(OF),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  pipe_execute #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA[31:0]), .E_valB(E_valB[31:0]), .E_valC(E_valC[31:0]),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .cc_inhibit(cc_inhibit), .m_stall(m_stall), .m_bubble(m_bubble),
    .e_valE(e_valE32), .e_dstE(e_dstE32), .ZF(ZF32), .SF(SF32), .OF(OF32),
    .M_stat(M_stat32), .M_icode(M_icode32), .M_cnd(M_cnd32), .M_valE(M_valE32),
    .M_valA(M_valA32), .M_dstE(M_dstE32), .M_dstM(M_dstM32)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mZF = 1'b1; mSF = 1'b0; mOF = 1'b0;
    xStat = 3'd0; xIcode = 4'd1; xCnd = 1'b0;
    xValE = '0; xValA = '0; xDstE = 4'hF; xDstM = 4'hF;
  endtask

  // Behavioural execute: signed arithmetic in W+1 bits gives overflow directly.
  task automatic modelExecute(output logic [W-1:0] valE, output logic [3:0] dstE,
                              output logic cnd, output logic [2:0] stat,
                              output logic setCc, output logic nz, output logic ns, output logic no);
    logic [W-1:0] a, b, step;
    logic [W:0]   wide;
    logic         cond;
    int           fun;
    step = W / 8;
    a = '0; b = '0; no = 1'b0; valE = '0;
    case (E_icode)
      4'd2, 4'd6:       a = E_valA;
      4'd3, 4'd4, 4'd5: a = E_valC;
      4'd8, 4'd10:      a = -step;
      4'd9, 4'd11:      a = step;
      default:          a = '0;
    endcase
    if (E_icode inside {4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11}) b = E_valB;
    fun = (E_icode == 4'd6) ? int'(E_ifun) : 0;
    case (fun)
      0: begin wide = {b[W-1], b} + {a[W-1], a}; valE = wide[W-1:0]; no = wide[W] != wide[W-1]; end
      1: begin wide = {b[W-1], b} - {a[W-1], a}; valE = wide[W-1:0]; no = wide[W] != wide[W-1]; end
      2: valE = a & b;
      3: valE = a ^ b;
      default: valE = '0;
    endcase
    case (E_ifun)
      4'd0: cond = 1'b1;
      4'd1: cond = (mSF ^ mOF) | mZF;
      4'd2: cond = mSF ^ mOF;
      4'd3: cond = mZF;
      4'd4: cond = !mZF;
      4'd5: cond = !(mSF ^ mOF);
      4'd6: cond = !(mSF ^ mOF) && !mZF;
      default: cond = 1'b0;
    endcase
    cnd   = (E_icode == 4'd2 || E_icode == 4'd7) ? cond : 1'b0;
    dstE  = (E_icode == 4'd2 && !cond) ? 4'hF : E_dstE;
    stat  = (E_icode == 4'd6 && fun > 3 && E_stat == 3'd1) ? 3'd4 : E_stat;
    setCc = (E_icode == 4'd6) && (fun <= 3) && (E_stat == 3'd1) && !cc_inhibit && !m_stall;
    nz = (valE == '0);
    ns = valE[W-1];
  endtask

  // One cycle: inputs already driven after a negedge; check forwarding, clock, check state.
  task automatic applyStimulus();
    logic [W-1:0] valE;
    logic [3:0]   dstE;
    logic         cnd, setCc, nz, ns, no;
    logic [2:0]   stat;
    #1;
    modelExecute(valE, dstE, cnd, stat, setCc, nz, ns, no);
    checkOutput("e_valE", e_valE, valE);
    checkOutput("e_dstE", e_dstE, dstE);
    @(posedge clk);
    if (setCc) begin mZF = nz; mSF = ns; mOF = no; end
    if (!m_stall) begin
      if (m_bubble) begin
        xStat = 3'd0; xIcode = 4'd1; xCnd = 1'b0; xValE = '0; xValA = '0; xDstE = 4'hF; xDstM = 4'hF;
      end else begin
        xStat = stat; xIcode = E_icode; xCnd = cnd; xValE = valE; xValA = E_valA;
        xDstE = dstE; xDstM = E_dstM;
      end
    end
    #1;
    checkOutput("ZF", ZF, mZF);
    checkOutput("SF", SF, mSF);
    checkOutput("OF", OF, mOF);
    checkOutput("M_stat", M_stat, xStat);
    checkOutput("M_icode", M_icode, xIcode);
    checkOutput("M_cnd", M_cnd, xCnd);
    checkOutput("M_valE", M_valE, xValE);
    checkOutput("M_valA", M_valA, xValA);
    checkOutput("M_dstE", M_dstE, xDstE);
    checkOutput("M_dstM", M_dstM, xDstM);
    @(negedge clk);
  endtask

  task automatic setInstr(input logic [3:0] icode, input logic [3:0] ifun,
                          input logic [W-1:0] valA, input logic [W-1:0] valB,
                          input logic [W-1:0] valC, input logic [3:0] dstE);
    E_stat = 3'd1; E_icode = icode; E_ifun = ifun;
    E_valA = valA; E_valB = valB; E_valC = valC;
    E_dstE = dstE; E_dstM = 4'hF;
    cc_inhibit = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    setInstr(4'd1, 4'd0, '0, '0, '0, 4'hF);
    modelReset();
    #1;
    checkOutput("rstZF", ZF, 1'b1);
    checkOutput("rstSF", SF, 1'b0);
    checkOutput("rstIcode", M_icode, 4'd1);
    checkOutput("rstDstE", M_dstE, 4'hF);
    @(negedge clk);
    rst = 1'b0;

    // addq overflow into the sign bit
    setInstr(4'd6, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, '0, 4'd2);
    applyStimulus();
    checkOutput("addValE", M_valE, 64'h8000_0000_0000_0000);
    checkOutput("addSF", SF, 1'b1);
    checkOutput("addOF", OF, 1'b1);
    checkOutput("addZF", ZF, 1'b0);

    // subq equal operands, then conditional jumps
    setInstr(4'd6, 4'd1, 64'd5, 64'd5, '0, 4'd3);
    applyStimulus();
    checkOutput("subValE", M_valE, 64'd0);
    checkOutput("subZF", ZF, 1'b1);
    setInstr(4'd7, 4'd1, '0, '0, 64'h40, 4'hF);
    applyStimulus();
    checkOutput("jleCnd", M_cnd, 1'b1);
    setInstr(4'd7, 4'd6, '0, '0, 64'h40, 4'hF);
    applyStimulus();
    checkOutput("jgCnd", M_cnd, 1'b0);

    // cmovne with ZF set is squashed
    setInstr(4'd2, 4'd4, 64'h42, 64'h999, '0, 4'd3);
    #1 checkOutput("cmovFwdDst", e_dstE, 4'hF);
    applyStimulus();
    checkOutput("cmovDstE", M_dstE, 4'hF);
    checkOutput("cmovValE", M_valE, 64'h42);

    // stack adjustments for both widths
    setInstr(4'd10, 4'd0, 64'h7, 64'h100, '0, 4'd4);
    #1 checkOutput("push32", e_valE32, 32'hFC);
    applyStimulus();
    checkOutput("pushValE", M_valE, 64'hF8);
    setInstr(4'd11, 4'd0, 64'h7, 64'h100, '0, 4'd4);
    #1 checkOutput("pop32", e_valE32, 32'h104);
    applyStimulus();
    checkOutput("popValE", M_valE, 64'h108);

    // clear ZF, then an inhibited zero-result subq must leave CC alone
    setInstr(4'd6, 4'd0, 64'd1, 64'd1, '0, 4'd1);
    applyStimulus();
    checkOutput("add2ZF", ZF, 1'b0);
    setInstr(4'd6, 4'd1, 64'd3, 64'd3, '0, 4'd2);
    cc_inhibit = 1'b1;
    applyStimulus();
    checkOutput("inhibitZF", ZF, 1'b0);

    // three stalled cycles, then release: M held, CC updated once
    setInstr(4'd6, 4'd1, 64'd9, 64'd9, '0, 4'd6);
    m_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("stallDstE", M_dstE, 4'd2);
      checkOutput("stallZF", ZF, 1'b0);
    end
    m_stall = 1'b0;
    applyStimulus();
    checkOutput("relDstE", M_dstE, 4'd6);
    checkOutput("relZF", ZF, 1'b1);

    // bubble, then stall+bubble holds
    m_bubble = 1'b1;
    applyStimulus();
    checkOutput("bubIcode", M_icode, 4'd1);
    checkOutput("bubStat", M_stat, 3'd0);
    setInstr(4'd3, 4'd0, '0, '0, 64'h55, 4'd1);
    applyStimulus();
    setInstr(4'd6, 4'd0, 64'd8, 64'd8, '0, 4'd5);
    m_stall = 1'b1; m_bubble = 1'b1;
    applyStimulus();
    checkOutput("bothIcode", M_icode, 4'd3);
    checkOutput("bothValE", M_valE, 64'h55);

    // undefined OPq function becomes INS
    setInstr(4'd6, 4'd5, 64'd8, 64'd8, '0, 4'd5);
    applyStimulus();
    checkOutput("insStat", M_stat, 3'd4);
    checkOutput("insValE", M_valE, 64'd0);

    // reset asserted mid-cycle during a stall
    setInstr(4'd6, 4'd0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, '0, 4'd7);
    applyStimulus();
    m_stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("midRstZF", ZF, 1'b1);
    checkOutput("midRstOF", OF, 1'b0);
    checkOutput("midRstIcode", M_icode, 4'd1);
    checkOutput("midRstStat", M_stat, 3'd0);
    checkOutput("midRstDstM", M_dstM, 4'hF);
    @(negedge clk);
    rst = 1'b0;
    setInstr(4'd3, 4'd0, '0, '0, 64'h1234, 4'd8);
    applyStimulus();

    // randomized instruction stream
    for (int n = 0; n < 400; n++) begin
      E_icode = 4'($urandom_range(0, 11));
      if (E_icode == 4'd6) E_ifun = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      else E_ifun = 4'($urandom_range(0, 8));
      E_stat = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 4)) : 3'd1;
      E_valA = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: E_valB = E_valA;
        1: E_valB = 64'($urandom_range(0, 3));
        2: E_valB = {1'b0, 63'h7FFF_FFFF_FFFF_FFF0} + 64'($urandom_range(0, 31));
        default: E_valB = {$urandom, $urandom};
      endcase
      E_valC = {$urandom, $urandom};
      E_dstE = 4'($urandom);
      E_dstM = 4'($urandom);
      cc_inhibit = ($urandom_range(0, 5) == 0);
      m_stall    = ($urandom_range(0, 4) == 0);
      m_bubble   = ($urandom_range(0, 5) == 0);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
